// File: rtl/wb_merge_if.sv
// Writeback merge bus: pipeline result, long-latency handshake and the
// register file write port, bundled so the merge stage and its driver
// share one definition.
interface wb_merge_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_rd;
  logic [31:0]   pipe_data;
  logic          lu_valid;
  logic          lu_ready;
  logic [4:0]    lu_rd;
  logic [31:0]   lu_data;
  logic          WE3;
  logic [4:0]    A3;
  logic [31:0]   D3;
  logic          hold_req;
  logic [CW-1:0] lu_count;

  modport master (
    output pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, WE3, A3, D3, hold_req, lu_count
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    output lu_ready, WE3, A3, D3, hold_req, lu_count
  );
endinterface

// File: rtl/wb_merge.sv
// Writeback merge stage: the in-order pipeline always owns the register
// file write port; long-latency results are bypassed when the port is
// free, otherwise parked in a small FIFO and drained on idle cycles.
// A starvation counter raises hold_req so the FIFO head eventually wins.
module wb_merge #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic       clk,
  input logic       rst,
  wb_merge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [4:0]    rdMem_q   [DEPTH];
  logic [31:0]   dataMem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  logic [4:0]    a_q, a_d;
  logic [31:0]   d_q, d_d;

  logic pipeWrite;
  logic luReady;
  logic luKeep;
  logic fifoEmpty;
  logic pop;
  logic bypass;
  logic push;

  // A pipe write to x0 is no write at all; an accepted lu result for x0
  // is consumed but dropped. The FIFO may only grow while it has room,
  // regardless of a pop happening in the same cycle.
  assign pipeWrite = bus.pipe_we && (bus.pipe_rd != 5'd0);
  assign luReady   = !rst && (count_q < FULL);
  assign luKeep    = bus.lu_valid && luReady && (bus.lu_rd != 5'd0);
  assign fifoEmpty = (count_q == '0);
  assign pop       = !pipeWrite && !fifoEmpty;
  assign bypass    = !pipeWrite && fifoEmpty && luKeep;
  assign push      = luKeep && !bypass;

  assign bus.lu_ready = luReady;
  assign bus.WE3      = we_q;
  assign bus.A3       = a_q;
  assign bus.D3       = d_q;
  assign bus.lu_count = count_q;
  assign bus.hold_req = (starve_q == LIMIT);

  // Select the next write-port source and advance FIFO/starvation state.
  always_comb begin
    we_d     = 1'b0;
    a_d      = a_q;
    d_d      = d_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    starve_d = '0;

    if (pipeWrite) begin
      we_d = 1'b1;
      a_d  = bus.pipe_rd;
      d_d  = bus.pipe_data;
    end else if (pop) begin
      we_d    = 1'b1;
      a_d     = rdMem_q[rdPtr_q];
      d_d     = dataMem_q[rdPtr_q];
      rdPtr_d = rdPtr_q + AW'(1);
    end else if (bypass) begin
      we_d = 1'b1;
      a_d  = bus.lu_rd;
      d_d  = bus.lu_data;
    end

    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end

    if (!fifoEmpty && pipeWrite) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + SW'(1);
    end
  end

  // Control and output registers; reset drops any buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      a_q      <= a_d;
      d_q      <= d_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rdMem_q[wrPtr_q]   <= bus.lu_rd;
      dataMem_q[wrPtr_q] <= bus.lu_data;
    end
  end
endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: directed vector table, a starvation
// sequence and randomized traffic against a queue-based reference model.
module tb_wb_merge;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    bit          r;
    bit          w;
    logic [4:0]  prd;
    logic [31:0] pdata;
    bit          lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    bit          expWe;
    logic [4:0]  expA;
    logic [31:0] expD;
    int          expCount;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  wb_merge_if #(.DEPTH(DEPTH)) bus();

  wb_merge #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference view of the model's state.
  ent_t        fifoQ[$];
  int          mStarve = 0;
  bit          mWe     = 1'b0;
  logic [4:0]  mA      = '0;
  logic [31:0] mD      = '0;
  bit          mAdCheck = 1'b0;
  int          checks  = 0;
  int          errors  = 0;
  logic [31:0] tbRegs [32];

  // Register file as seen by the write port: written on the falling edge.
  always @(negedge clk) begin
    if (bus.WE3) tbRegs[bus.A3] <= bus.D3;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of the reference: priority pipe > queued head > bypass.
  task automatic modelStep(input bit r, input bit w, input logic [4:0] prd, input logic [31:0] pdata,
                           input bit lv, input logic [4:0] lrd, input logic [31:0] ldata);
    ent_t e;
    bit pe, wasEmpty, keep;
    mAdCheck = 1'b0;
    if (r) begin
      fifoQ.delete();
      mStarve  = 0;
      mWe      = 1'b0;
      mA       = '0;
      mD       = '0;
      mAdCheck = 1'b1;
      return;
    end
    pe       = w && (prd != 0);
    wasEmpty = (fifoQ.size() == 0);
    keep     = lv && (fifoQ.size() < DEPTH) && (lrd != 0);
    if (!wasEmpty && pe) mStarve = (mStarve < STARVE_LIMIT) ? mStarve + 1 : mStarve;
    else mStarve = 0;
    if (pe) begin
      mWe = 1'b1; mA = prd; mD = pdata;
    end else if (!wasEmpty) begin
      e = fifoQ.pop_front();
      mWe = 1'b1; mA = e.rd; mD = e.data;
    end else if (keep) begin
      mWe = 1'b1; mA = lrd; mD = ldata;
      keep = 1'b0;
    end else begin
      mWe = 1'b0;
    end
    if (keep) begin
      e.rd = lrd; e.data = ldata;
      fifoQ.push_back(e);
    end
  endtask

  // Drive one cycle, check combinational outputs mid-cycle and the
  // registered write port just after the edge.
  task automatic applyStimulus(input bit r, input bit w, input logic [4:0] prd, input logic [31:0] pdata,
                               input bit lv, input logic [4:0] lrd, input logic [31:0] ldata);
    rst           = r;
    bus.pipe_we   = w;
    bus.pipe_rd   = prd;
    bus.pipe_data = pdata;
    bus.lu_valid  = lv;
    bus.lu_rd     = lrd;
    bus.lu_data   = ldata;
    @(negedge clk);
    checkOutput("lu_ready", 32'(bus.lu_ready), 32'(!r && (fifoQ.size() < DEPTH)));
    checkOutput("hold_req", 32'(bus.hold_req), 32'(mStarve == STARVE_LIMIT));
    checkOutput("lu_count", 32'(bus.lu_count), 32'(fifoQ.size()));
    @(posedge clk);
    modelStep(r, w, prd, pdata, lv, lrd, ldata);
    #1;
    checkOutput("WE3", 32'(bus.WE3), 32'(mWe));
    if (mWe || mAdCheck) begin
      checkOutput("A3", 32'(bus.A3), 32'(mA));
      checkOutput("D3", bus.D3, mD);
    end
  endtask

  vec_t vecs[15];

  initial begin
    bit          r, w, lv;
    logic [4:0]  prd, lrd;
    logic [31:0] pdata, ldata;

    // Directed vectors: {rst, pipe, lu, expected WE3/A3/D3, lu_count}.
    vecs[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,        0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,        0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  32'h11, 1'b1, 5'd7, 32'h11,       0};
    vecs[4]  = '{1'b0, 1'b1, 5'd1, 32'h100,      1'b1, 5'd2,  32'h22, 1'b1, 5'd1, 32'h100,      1};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3,  32'h33, 1'b1, 5'd2, 32'h22,       1};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd3, 32'h33,       0};
    vecs[7]  = '{1'b0, 1'b1, 5'd0, 32'h55,       1'b1, 5'd0,  32'h77, 1'b0, 5'd0, 32'h0,        0};
    vecs[8]  = '{1'b0, 1'b1, 5'd1, 32'h1,        1'b1, 5'd6,  32'h66, 1'b1, 5'd1, 32'h1,        1};
    vecs[9]  = '{1'b0, 1'b1, 5'd0, 32'h99,       1'b0, 5'd0,  32'h0,  1'b1, 5'd6, 32'h66,       0};
    vecs[10] = '{1'b0, 1'b1, 5'd2, 32'h2,        1'b1, 5'd8,  32'h88, 1'b1, 5'd2, 32'h2,        1};
    vecs[11] = '{1'b0, 1'b1, 5'd3, 32'h3,        1'b1, 5'd9,  32'h99, 1'b1, 5'd3, 32'h3,        2};
    vecs[12] = '{1'b1, 1'b1, 5'd4, 32'h4,        1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 32'h0,        0};
    vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,        0};
    vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,        0};

    rst = 1'b1;
    bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_data = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].r, vecs[i].w, vecs[i].prd, vecs[i].pdata,
                    vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      checkOutput("vecWE3", 32'(bus.WE3), 32'(vecs[i].expWe));
      if (vecs[i].expWe || vecs[i].r) begin
        checkOutput("vecA3", 32'(bus.A3), 32'(vecs[i].expA));
        checkOutput("vecD3", bus.D3, vecs[i].expD);
      end
      checkOutput("vecCount", 32'(bus.lu_count), 32'(vecs[i].expCount));
    end
    checkOutput("regfileX5", tbRegs[5], 32'hDEADBEEF);

    $display("[TB] starvation sequence");
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      lrd   = (k == 0) ? 5'd8 : (k == 1) ? 5'd9 : 5'd10;
      ldata = (k == 0) ? 32'hA : (k == 1) ? 32'hB : 32'hC;
      applyStimulus(1'b0, 1'b1, 5'(k + 1), 32'h100 + 32'(k), 1'b1, lrd, ldata);
      if (k == 1) checkOutput("seqReadyFull", 32'(bus.lu_ready), 32'd0);
    end
    checkOutput("seqCountFull", 32'(bus.lu_count), 32'd2);
    checkOutput("seqHoldHigh", 32'(bus.hold_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("seqPop1A3", 32'(bus.A3), 32'd8);
    checkOutput("seqPop1D3", bus.D3, 32'hA);
    checkOutput("seqHoldClear", 32'(bus.hold_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("seqPop2A3", 32'(bus.A3), 32'd9);
    checkOutput("seqPop2D3", bus.D3, 32'hB);
    checkOutput("seqDrained", 32'(bus.lu_count), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      w   = ($urandom_range(0, 99) < 60);
      if (mStarve == STARVE_LIMIT && $urandom_range(0, 3) != 0) w = 1'b0;
      prd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pdata = $urandom;
      lv    = ($urandom_range(0, 99) < 50);
      lrd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ldata = $urandom;
      applyStimulus(r, w, prd, pdata, lv, lrd, ldata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
